// File: rtl/cnn_ch_accumulator.sv
// Per-pixel channel reducer: sums CI kernel partials, adds bias, optional ReLU,
// saturates to DATA_LEN and tracks pixel position within the output feature map.
module cnn_ch_accumulator #(
    parameter int CI       = 3,
    parameter int DATA_LEN = 8,
    parameter int ACC_LEN  = 20,
    parameter int NUM_PIX  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_soft_reset,
    input  logic                       i_in_valid,
    input  logic signed [DATA_LEN-1:0] i_in_kernel_acc,
    input  logic signed [DATA_LEN-1:0] i_bias,
    input  logic                       i_relu_en,
    output logic                       o_ot_valid,
    output logic signed [DATA_LEN-1:0] o_ot_ch_acc,
    output logic                       o_ot_last,
    output logic                       o_ot_busy
);
    localparam int CH_W  = (CI > 1) ? $clog2(CI) : 1;
    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CI - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
    localparam logic signed [ACC_LEN-1:0] SAT_MAX =
        {{(ACC_LEN-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [ACC_LEN-1:0] SAT_MIN =
        {{(ACC_LEN-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_cnt_q, ch_cnt_d;
    logic [PIX_W-1:0]             pix_cnt_q, pix_cnt_d;
    logic signed [ACC_LEN-1:0]    acc_q, acc_d;
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic signed [DATA_LEN-1:0]   data_q, data_d;

    logic signed [ACC_LEN-1:0]    in_ext, bias_ext, sum, act;
    logic signed [DATA_LEN-1:0]   sat;
    logic                         last_ch;

    always_comb begin
        in_ext   = {{(ACC_LEN-DATA_LEN){i_in_kernel_acc[DATA_LEN-1]}}, i_in_kernel_acc};
        bias_ext = {{(ACC_LEN-DATA_LEN){i_bias[DATA_LEN-1]}}, i_bias};
        // acc_q is zero in IDLE, so the same adder serves channel 0 and the CI=1 build
        sum      = acc_q + in_ext + bias_ext;
        act      = (i_relu_en && sum[ACC_LEN-1]) ? '0 : sum;
        if (act > SAT_MAX)      sat = SAT_MAX[DATA_LEN-1:0];
        else if (act < SAT_MIN) sat = SAT_MIN[DATA_LEN-1:0];
        else                    sat = act[DATA_LEN-1:0];
        last_ch  = (CI == 1) || (state_q == ACC && ch_cnt_q == CH_LAST);

        state_d   = state_q;
        ch_cnt_d  = ch_cnt_q;
        pix_cnt_d = pix_cnt_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        data_d    = data_q;

        if (i_soft_reset) begin
            state_d   = IDLE;
            ch_cnt_d  = '0;
            pix_cnt_d = '0;
            acc_d     = '0;
            data_d    = '0;
        end else if (i_in_valid) begin
            if (last_ch) begin
                valid_d   = 1'b1;
                data_d    = sat;
                last_d    = (pix_cnt_q == PIX_LAST);
                pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
                acc_d     = '0;
                ch_cnt_d  = '0;
                state_d   = IDLE;
            end else begin
                acc_d    = acc_q + in_ext;
                ch_cnt_d = ch_cnt_q + 1'b1;
                state_d  = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ch_cnt_q  <= '0;
            pix_cnt_q <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_cnt_q  <= ch_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
        end
    end

    assign o_ot_valid  = valid_q;
    assign o_ot_last   = last_q;
    assign o_ot_ch_acc = data_q;
    assign o_ot_busy   = (state_q == ACC);
endmodule

// File: tb/tb_cnn_ch_accumulator.sv
// Scoreboard bench: directed pixels on a CI=3 and a CI=1 build, monitor pops expected results.
module tb_cnn_ch_accumulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, srst, v3, relu3;
    logic signed [7:0] in3, b3, od3;
    logic ov3, ol3, ob3;

    logic rst1_n, v1, srst1, relu1;
    logic signed [7:0] in1, b1, od1;
    logic ov1, ol1, ob1;

    cnn_ch_accumulator #(.CI(3), .DATA_LEN(8), .ACC_LEN(20), .NUM_PIX(16)) dut3 (
        .clk(clk), .reset_n(rst_n), .i_soft_reset(srst), .i_in_valid(v3),
        .i_in_kernel_acc(in3), .i_bias(b3), .i_relu_en(relu3),
        .o_ot_valid(ov3), .o_ot_ch_acc(od3), .o_ot_last(ol3), .o_ot_busy(ob3));

    cnn_ch_accumulator #(.CI(1), .DATA_LEN(8), .ACC_LEN(20), .NUM_PIX(4)) dut1 (
        .clk(clk), .reset_n(rst1_n), .i_soft_reset(srst1), .i_in_valid(v1),
        .i_in_kernel_acc(in1), .i_bias(b1), .i_relu_en(relu1),
        .o_ot_valid(ov1), .o_ot_ch_acc(od1), .o_ot_last(ol1), .o_ot_busy(ob1));

    typedef struct packed {logic signed [7:0] d; logic last;} exp_t;
    exp_t q3[$], q1[$];
    int nvec = 0, nerr = 0;
    int pix3 = 0, pix1 = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp3(input int d);
        exp_t e;
        e.d = 8'(d); e.last = (pix3 == 15);
        q3.push_back(e);
        pix3 = (pix3 == 15) ? 0 : pix3 + 1;
    endtask

    task automatic exp1(input int d);
        exp_t e;
        e.d = 8'(d); e.last = (pix1 == 3);
        q1.push_back(e);
        pix1 = (pix1 == 3) ? 0 : pix1 + 1;
    endtask

    task automatic c3(input logic v, input int x, input int b, input logic r, input logic s);
        @(negedge clk);
        v3 = v; in3 = 8'(x); b3 = 8'(b); relu3 = r; srst = s;
    endtask

    task automatic c1(input logic v, input int x, input int b);
        @(negedge clk);
        v1 = v; in1 = 8'(x); b1 = 8'(b);
    endtask

    exp_t e3, e1;
    always @(negedge clk) begin
        if (ov3 === 1'b1) begin
            if (q3.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL dut3 unexpected pulse: got data %0d expected no output", od3);
            end else begin
                e3 = q3.pop_front();
                chk("dut3 data", od3, e3.d);
                chk("dut3 last", ol3, e3.last);
            end
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL dut1 unexpected pulse: got data %0d expected no output", od1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 data", od1, e1.d);
                chk("dut1 last", ol1, e1.last);
            end
        end
    end

    initial begin
        rst_n = 0; srst = 0; v3 = 0; in3 = 0; b3 = 0; relu3 = 0;
        rst1_n = 0; srst1 = 0; v1 = 0; in1 = 0; b1 = 0; relu1 = 0;
        #1;
        chk("rst valid3", ov3, 0); chk("rst data3", od3, 0);
        chk("rst last3", ol3, 0);  chk("rst busy3", ob3, 0);
        chk("rst valid1", ov1, 0); chk("rst data1", od1, 0);
        #20;
        rst_n = 1; rst1_n = 1;

        // 10+20+30+5; bias on non-final cycles must be ignored
        c3(1, 10, 99, 0, 0);
        c3(1, 20, 99, 0, 0); chk("busy after ch0", ob3, 1);
        exp3(65);
        c3(1, 30, 5, 0, 0);  chk("busy after ch1", ob3, 1);
        c3(0, 0, 0, 0, 0);   chk("busy after ch2", ob3, 0);

        c3(1, 100, 0, 0, 0); c3(1, 100, 0, 0, 0); exp3(127); c3(1, 100, 0, 0, 0);
        c3(1, -100, 0, 0, 0); c3(1, -100, 0, 0, 0); exp3(-128); c3(1, -100, 0, 0, 0);
        c3(1, -10, 0, 1, 0); c3(1, -20, 0, 1, 0); exp3(0); c3(1, 5, 0, 1, 0);
        c3(1, -10, 0, 0, 0); c3(1, -20, 0, 0, 0); exp3(-25); c3(1, 5, 0, 0, 0);

        // gaps between channels: 1+2+3+bias 4
        c3(1, 1, 0, 0, 0);
        repeat (3) c3(0, 0, 0, 0, 0);
        chk("busy held in gap", ob3, 1);
        c3(1, 2, 0, 0, 0); exp3(10); c3(1, 3, 4, 0, 0);
        c3(0, 0, 0, 0, 0);

        // soft reset after two partials, with a coincident valid that is dropped
        c3(1, 9, 0, 0, 0); c3(1, 9, 0, 0, 0); c3(1, 9, 0, 0, 1);
        pix3 = 0;
        c3(1, 4, 0, 0, 0); chk("busy after soft reset", ob3, 0);
        c3(1, 4, 0, 0, 0); exp3(12); c3(1, 4, 0, 0, 0);
        c3(0, 0, 0, 0, 1);
        pix3 = 0;

        // 17 back-to-back pixels: pixel k = k+1+1; last only on the 16th
        for (int k = 0; k < 17; k++) begin
            c3(1, k, 0, 0, 0); c3(1, 1, 0, 0, 0);
            exp3(k + 2); c3(1, 1, 0, 0, 0);
        end
        c3(0, 0, 0, 0, 0);
        repeat (3) c3(0, 0, 0, 0, 0);

        // CI=1 build: every valid finalizes, 7+1 each cycle
        for (int k = 0; k < 6; k++) begin
            exp1(8); c1(1, 7, 1);
        end
        c1(0, 0, 0);
        #2 rst1_n = 0;
        #1;
        chk("async rst valid1", ov1, 0);
        chk("async rst data1", od1, 0);
        chk("async rst last1", ol1, 0);
        @(negedge clk) rst1_n = 1;
        pix1 = 0;
        for (int k = 0; k < 5; k++) begin
            exp1(8); c1(1, 7, 1);
        end
        c1(0, 0, 0);
        repeat (4) @(negedge clk);

        chk("dut3 queue drained", q3.size(), 0);
        chk("dut1 queue drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cnn_ch_accumulator.md
# cnn_ch_accumulator

Downstream stage of the per-channel kernel MAC: sums the CI per-input-channel kernel results (`o_ot_kernel_acc`) belonging to one output pixel, adds a per-output-channel bias, applies optional ReLU, saturates to DATA_LEN and emits one registered result per pixel. It also counts output pixels per feature map and flags the last one, so the writeback stage can close the map.

## Interface
- CI, 3: input channels summed per output pixel (≥1)
- DATA_LEN, 8: width of input partials, bias and output (signed two's complement)
- ACC_LEN, 20: internal accumulator width (≥ DATA_LEN + clog2(CI+1))
- NUM_PIX, 16: output pixels per feature map (≥1)
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_soft_reset  input  1  synchronous clear, same effect as reset_n, lower priority
- i_in_valid  input  1  partial sum valid (one channel per pulse)
- i_in_kernel_acc  input  DATA_LEN  signed partial sum from kernel stage
- i_bias  input  DATA_LEN  signed bias, sampled on the final-channel cycle
- i_relu_en  input  1  1 = clamp negatives to 0; quasi-static per map
- o_ot_valid  output  1  one-cycle pulse, result valid
- o_ot_ch_acc  output  DATA_LEN  biased, activated, saturated result
- o_ot_last  output  1  high with o_ot_valid on pixel NUM_PIX-1 of a map
- o_ot_busy  output  1  high while a pixel is partially accumulated

## Operation
- State: ch_cnt (0..CI-1), acc (ACC_LEN signed), pix_cnt (0..NUM_PIX-1), FSM {IDLE, ACC}.
- IDLE: ch_cnt=0, acc=0. Valid with CI>1 -> acc=sext(in), ch_cnt=1, go ACC. Valid with CI=1 -> finalize immediately, stay IDLE.
- ACC: valid with ch_cnt<CI-1 -> acc+=sext(in), ch_cnt++. Valid with ch_cnt=CI-1 -> finalize, acc=0, ch_cnt=0, go IDLE. No valid -> hold (gaps between channels allowed, unbounded).
- Finalize: sum = acc + sext(in) + sext(i_bias) in ACC_LEN; if i_relu_en and sum<0 -> 0; then saturate to [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1]; register into o_ot_ch_acc; pulse o_ot_valid.
- pix_cnt increments on each finalize; at NUM_PIX-1 o_ot_last=1 with that result and pix_cnt wraps to 0.
- o_ot_ch_acc holds last result between pulses; o_ot_valid/o_ot_last are single-cycle.
- o_ot_busy = (state==ACC).
- Accumulator never wraps for legal ACC_LEN; saturation applied only at output.

## Timing
- Reset values (reset_n low or i_soft_reset high at edge): o_ot_valid=0, o_ot_ch_acc=0, o_ot_last=0, o_ot_busy=0, ch_cnt=0, acc=0, pix_cnt=0, FSM=IDLE.
- Latency: o_ot_valid asserts the cycle after the edge sampling the final-channel valid.
- Throughput: one partial per cycle; back-to-back pixels with no bubble (valid on the cycle o_ot_valid is high is accepted as channel 0 of next pixel).
- Soft reset mid-pixel: partial sum discarded, no output pulse; valid coincident with i_soft_reset is dropped.
- reset_n mid-pixel: asynchronous clear of all state and outputs.
- i_bias/i_relu_en changes between final-channel cycles have no effect on in-flight result.

## Test plan
- CI=3: partials 10,20,30, bias 5, relu off -> one o_ot_valid, o_ot_ch_acc=65, o_ot_busy high for 2 cycles.
- Saturation: partials 100,100,100, bias 0 -> 127; partials -100,-100,-100, relu off -> -128 (0x80).
- ReLU: partials -10,-20,5, bias 0: relu on -> 0; relu off -> -25 (0xE7).
- Streaming NUM_PIX=16, valid every cycle for 48 cycles -> 16 pulses spaced 3 cycles, o_ot_last only on 16th, pix_cnt wraps; 17th pixel has o_ot_last=0.
- Gaps/soft reset: partials 1,(3 idle),2,3 -> 6+bias; soft reset after 2 of 3 partials -> no output, next 3 partials 4,4,4 bias 0 -> 12.
- CI=1 build: each valid with value 7, bias 1 -> 8 one cycle later, every cycle; async reset_n pulse mid-stream clears outputs to 0 immediately.
